// File: rtl/instruction_sequencer.sv
// Streams a preloaded program memory to a consumer; optional SEQUENCER_LOOP_EN adds loop_in for gapless wraparound.
// First word valid two cycles after start; stall_in holds the presented word, abort_in drops straight back to IDLE.
module instruction_sequencer #(
  parameter  int DEPTH  = 64,
  parameter  int DATA_W = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              load_valid_in,
  input  logic [ADDR_W-1:0] load_addr_in,
  input  logic [DATA_W-1:0] load_data_in,
  output logic              load_ready_out,
  input  logic              start_in,
  input  logic [ADDR_W:0]   length_in,
  input  logic              stall_in,
  input  logic              abort_in,
`ifdef SEQUENCER_LOOP_EN
  input  logic              loop_in,
`endif
  output logic [DATA_W-1:0] current_instruction,
  output logic              instruction_valid_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy_out,
  output logic              done_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   clamped;
  logic              last;
  logic              loop;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef SEQUENCER_LOOP_EN
  assign loop = loop_in;
`else
  assign loop = 1'b0;
`endif

  assign clamped        = (length_in > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : length_in;
  assign last           = (({1'b0, pc} + (ADDR_W+1)'(1)) == len);
  assign load_ready_out = (state == IDLE);

  // Program memory is deliberately outside the reset domain so a reset keeps the loaded program.
  always_ff @(posedge clock_in) begin
    if (state == IDLE && load_valid_in && ({1'b0, load_addr_in} < (ADDR_W+1)'(DEPTH)))
      mem[load_addr_in] <= load_data_in;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      pc                    <= '0;
      len                   <= '0;
      current_instruction   <= '0;
      instruction_valid_out <= 1'b0;
      pc_out                <= '0;
      busy_out              <= 1'b0;
      done_out              <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          instruction_valid_out <= 1'b0;
          current_instruction   <= '0;
          if (start_in && !load_valid_in) begin
            pc  <= '0;
            len <= clamped;
            if (clamped == '0) begin
              state <= DONE;
            end else begin
              state    <= RUN;
              busy_out <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort_in) begin
            state                 <= IDLE;
            busy_out              <= 1'b0;
            instruction_valid_out <= 1'b0;
            current_instruction   <= '0;
          end else if (!stall_in) begin
            current_instruction   <= mem[pc];
            instruction_valid_out <= 1'b1;
            pc_out                <= pc;
            if (!last) begin
              pc <= pc + ADDR_W'(1);
            end else if (loop) begin
              pc <= '0;
            end else begin
              state    <= DONE;
              busy_out <= 1'b0;
            end
          end
        end
        DONE: begin
          // The last word stays visible for one cycle, then the NOP/done cycle follows.
          instruction_valid_out <= 1'b0;
          current_instruction   <= '0;
          done_out              <= 1'b1;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized self-checking bench for instruction_sequencer against a word-queue reference model.
module tb_instruction_sequencer;
  localparam int DEPTH  = 64;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;

  logic              clock_in = 1'b0;
  logic              reset_n  = 1'b0;
  logic              load_valid_in = 1'b0;
  logic [ADDR_W-1:0] load_addr_in  = '0;
  logic [DATA_W-1:0] load_data_in  = '0;
  logic              load_ready_out;
  logic              start_in  = 1'b0;
  logic [ADDR_W:0]   length_in = '0;
  logic              stall_in  = 1'b0;
  logic              abort_in  = 1'b0;
  logic              loop_in   = 1'b0;
  logic [DATA_W-1:0] current_instruction;
  logic              instruction_valid_out;
  logic [ADDR_W-1:0] pc_out;
  logic              busy_out;
  logic              done_out;

  logic [DATA_W-1:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  instruction_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock_in              (clock_in),
    .reset_n               (reset_n),
    .load_valid_in         (load_valid_in),
    .load_addr_in          (load_addr_in),
    .load_data_in          (load_data_in),
    .load_ready_out        (load_ready_out),
    .start_in              (start_in),
    .length_in             (length_in),
    .stall_in              (stall_in),
    .abort_in              (abort_in),
`ifdef SEQUENCER_LOOP_EN
    .loop_in               (loop_in),
`endif
    .current_instruction   (current_instruction),
    .instruction_valid_out (instruction_valid_out),
    .pc_out                (pc_out),
    .busy_out              (busy_out),
    .done_out              (done_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_word(input int a, input logic [DATA_W-1:0] d);
    load_valid_in = 1'b1;
    load_addr_in  = ADDR_W'(a);
    load_data_in  = d;
    @(posedge clock_in); #1;
    load_valid_in = 1'b0;
    model_mem[a] = d;
  endtask

  // Model: the run is the list of words mem[0..min(len,DEPTH)-1]; idx is the word on the outputs.
  // stall_mode 0 none, 1 random, 2 two stalls while word 1 is shown; abort_cnt>0 aborts after that many words.
  task automatic run_stream(input int len, input int stall_mode, input int abort_cnt,
                            input bit noise, input bit loop);
    int n, idx, shown, hold;
    bit st, ab, fin;
    n = (len > DEPTH) ? DEPTH : len;
    loop_in   = loop;
    start_in  = 1'b1;
    length_in = (ADDR_W+1)'(len);
    @(posedge clock_in); #1;
    start_in = 1'b0;
    @(negedge clock_in);
    check("entry_valid", instruction_valid_out, 0);
    check("entry_busy", busy_out, 64'(n > 0));
    check("entry_done", done_out, 0);
    idx = -1; shown = 0; hold = 0; fin = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      st = (stall_mode == 1) ? ($urandom_range(0, 2) == 0) : (stall_mode == 2 && idx == 1 && hold < 2);
      if (stall_mode == 2 && st) hold++;
      ab = (abort_cnt > 0 && shown == abort_cnt);
      stall_in = st;
      abort_in = ab;
      if (noise) begin
        load_valid_in = 1'($urandom_range(0, 1));
        load_addr_in  = ADDR_W'($urandom);
        load_data_in  = $urandom;
        start_in      = 1'($urandom_range(0, 1));
        length_in     = (ADDR_W+1)'($urandom);
      end
      @(posedge clock_in); #1;
      stall_in = 1'b0; abort_in = 1'b0; load_valid_in = 1'b0; start_in = 1'b0;
      @(negedge clock_in);
      if (idx == n - 1 && (!loop || n == 0)) begin
        check("done_pulse", done_out, 1);
        check("done_valid", instruction_valid_out, 0);
        check("done_nop", current_instruction, 0);
        fin = 1;
      end else if (ab) begin
        check("abort_valid", instruction_valid_out, 0);
        check("abort_nop", current_instruction, 0);
        check("abort_done", done_out, 0);
        fin = 1;
      end else begin
        if (!st) begin
          idx = (idx == n - 1) ? 0 : idx + 1;
          shown++;
        end
        check("stream_valid", instruction_valid_out, 64'(idx >= 0));
        check("stream_data", current_instruction, (idx >= 0) ? 64'(model_mem[idx]) : 64'(0));
        if (idx >= 0) check("stream_pc", pc_out, 64'(idx));
        check("stream_done", done_out, 0);
        if (idx < n - 1 || loop) check("stream_busy", busy_out, 1);
      end
    end
    if (!fin) check("stream_timeout", 0, 1);
    loop_in = 1'b0;
    @(negedge clock_in);
    check("post_done", done_out, 0);
    check("post_ready", load_ready_out, 1);
    check("post_valid", instruction_valid_out, 0);
  endtask

  initial begin
    repeat (2) @(negedge clock_in);
    check("rst_valid", instruction_valid_out, 0);
    check("rst_instr", current_instruction, 0);
    check("rst_pc", pc_out, 0);
    check("rst_done", done_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_ready", load_ready_out, 1);
    reset_n = 1'b1;
    @(negedge clock_in);

    for (int a = 0; a < DEPTH; a++) load_word(a, $urandom);
    for (int a = 0; a < 4; a++) load_word(a, 32'hA000_0000 + 32'(a));

    // Load and start together: the start is dropped, the write lands.
    load_valid_in = 1'b1; load_addr_in = 6'd10; load_data_in = 32'h1234_5678;
    start_in = 1'b1; length_in = 7'd5;
    @(posedge clock_in); #1;
    load_valid_in = 1'b0; start_in = 1'b0;
    model_mem[10] = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock_in);
      check("collide_busy", busy_out, 0);
      check("collide_valid", instruction_valid_out, 0);
      check("collide_done", done_out, 0);
    end

    run_stream(4, 0, 0, 0, 0);
    run_stream(4, 2, 0, 0, 0);
    run_stream(0, 0, 0, 0, 0);
    run_stream(100, 0, 0, 0, 0);
    run_stream(4, 0, 3, 1, 0);
    run_stream(64, 1, 0, 0, 0);

    // Asynchronous reset in the middle of a stream.
    @(negedge clock_in);
    start_in = 1'b1; length_in = 7'd20;
    @(posedge clock_in); #1;
    start_in = 1'b0;
    repeat (4) @(posedge clock_in);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", instruction_valid_out, 0);
    check("mid_rst_instr", current_instruction, 0);
    check("mid_rst_pc", pc_out, 0);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_done", done_out, 0);
    check("mid_rst_ready", load_ready_out, 1);
    repeat (2) @(negedge clock_in);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock_in);
      check("after_rst_done", done_out, 0);
      check("after_rst_valid", instruction_valid_out, 0);
    end
    run_stream(64, 1, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int len, ab;
      len = $urandom_range(0, 70);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
      run_stream(len, 1, ab, 1, 0);
    end
    run_stream(64, 0, 0, 0, 0);

`ifdef SEQUENCER_LOOP_EN
    run_stream(2, 0, 9, 0, 1);
    run_stream(5, 1, 13, 1, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
